ahfp_fixed_acc: RTL and testbench
=================================

# ahfp_fixed_acc

Streaming signed fixed-point frame accumulator that sits directly upstream of the AHFP fixed-to-float converter stage. It sums a frame of 32-bit two's-complement samples at full internal precision, then saturates the total to 32 bits. It presents the result on a held-stable output register that drives the converter's 32-bit fixed input. Saturation never produces 0x80000000, because the converter's negate-and-normalise path cannot represent it.

## Interface
- ACC_W, 40, internal accumulator width; must satisfy ACC_W >= 32 + clog2(MAX_LEN)
- MAX_LEN, 256, maximum beats per frame; frame auto-closes on the MAX_LEN-th beat
- CNT_W, clog2(MAX_LEN)+1 (derived, localparam), width of out_count
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample present on in_data
- in_data  in  32  signed two's-complement sample
- in_last  in  1  qualifies final beat of frame (valid only with in_valid)
- in_ready  out  1  block can accept a beat; combinational = !out_valid
- out_valid  out  1  out_data/out_sat/out_count hold a finished frame result
- out_ready  in  1  consumer takes result
- out_data  out  32  saturated frame sum, feeds the converter input
- out_sat  out  1  saturation applied to this result
- out_count  out  CNT_W  number of beats in the frame (1..MAX_LEN)

## Operation
- States: ACC (accepting beats) and HOLD (result presented). Reset enters ACC with acc=0, cnt=0.
- Beat accepted when in_valid && in_ready. Sample sign-extended to ACC_W and added to acc; cnt increments.
- Frame closes on an accepted beat with in_last=1, or on the beat that makes cnt == MAX_LEN (in_last ignored then).
- On close, the final sum (acc + sample) is saturated and registered into out_data. out_count = cnt+1, out_valid=1, state becomes HOLD, and acc/cnt clear to 0.
- Saturation rule: sum > 0x7FFFFFFF gives 0x7FFFFFFF; sum < -0x7FFFFFFF gives 0x80000001; either case sets out_sat=1. Otherwise out_data = sum[31:0] and out_sat=0.
- HOLD: outputs held stable, in_ready=0, in_valid ignored. When out_ready=1, out_valid clears on the next edge and the state returns to ACC.
- in_last without in_valid has no effect. in_valid during reset is ignored.
- No internal overflow for legal parameters: ACC_W wraps never occur; arithmetic is exact before saturation.
- Reset mid-frame or mid-HOLD: partial sum discarded, result dropped, all outputs at reset values.

## Timing
- Reset values: out_valid=0, out_data=0, out_sat=0, out_count=0. in_ready=1 combinationally, since out_valid=0.
- Throughput in ACC: one beat per cycle, no bubbles within a frame.
- Latency: out_valid rises on the clock edge that accepts the closing beat, so it is visible the cycle after that beat.
- Converter float output follows out_data by that stage's 1 register cycle. out_data must therefore be held at least until out_valid drops.
- Between frames: minimum one dead cycle. in_ready is 0 in the cycle where out_valid=1 and out_ready=1; the first beat of the next frame can be accepted in the following cycle.
- out_ready while out_valid=0 has no effect.
- Single-beat frame (in_last on the first beat) is legal: out_count=1.

## Test plan
- Frame 0x00000003, 0xFFFFFFFE, 0x00000010 (last), out_ready=1 -> out_data=0x00000011, out_count=3, out_sat=0, out_valid high for exactly 1 cycle.
- Two beats of 0x7FFFFFFF (last on 2nd) -> out_data=0x7FFFFFFF, out_sat=1. Two beats of 0x80000000 -> out_data=0x80000001, out_sat=1.
- Single beat 0x80000000 with in_last -> out_data=0x80000001, out_sat=1, out_count=1.
- 256 beats of 0x00000001 with in_last never asserted -> frame closes on beat 256, out_data=0x00000100, out_count=256. Beat 257 starts a new frame.
- Result held with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable, no beats consumed. Then out_ready=1 -> next frame accepted one cycle after out_valid falls.
- rst_n pulsed low after 2 beats of a frame -> all outputs at reset values asynchronously. A following 1-beat frame of 0x00000005 gives out_data=0x00000005, out_count=1.

Source files
------------

// File: rtl/ahfp_fixed_acc.sv
// rtl/ahfp_fixed_acc.sv - signed fixed-point frame accumulator with 32-bit symmetric saturation
// Result is held stable in HOLD until taken; 0x80000000 is never produced.
module ahfp_fixed_acc #(
    parameter int ACC_W   = 40,
    parameter int MAX_LEN = 256,
    localparam int CNT_W  = $clog2(MAX_LEN) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_sat,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic {ACC, HOLD} state_t;

    localparam logic signed [ACC_W-1:0] POS_MAX = {{(ACC_W-32){1'b0}}, 32'h7FFF_FFFF};
    localparam logic signed [ACC_W-1:0] NEG_MIN = -POS_MAX;
    localparam logic [CNT_W-1:0]        CNT_END = CNT_W'(MAX_LEN - 1);

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] sum;
    logic                    accept;
    logic                    close;
    logic                    sat_hi;
    logic                    sat_lo;

    assign in_ready  = !out_valid;
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign sum       = acc + {{(ACC_W-32){in_data[31]}}, in_data};
    assign sat_hi    = (sum > POS_MAX);
    assign sat_lo    = (sum < NEG_MIN);

    always_comb begin
        state_nxt = state;
        close     = 1'b0;
        case (state)
            ACC: begin
                // the MAX_LEN-th beat closes the frame regardless of in_last
                close = accept && (in_last || (cnt == CNT_END));
                if (close) state_nxt = HOLD;
            end
            HOLD: begin
                if (out_ready) state_nxt = ACC;
            end
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_count <= '0;
        end else if (close) begin
            acc       <= '0;
            cnt       <= '0;
            out_count <= cnt + CNT_W'(1);
            out_sat   <= sat_hi || sat_lo;
            if (sat_hi) begin
                out_data <= 32'h7FFF_FFFF;
            end else if (sat_lo) begin
                out_data <= 32'h8000_0001;
            end else begin
                out_data <= sum[31:0];
            end
        end else if (accept) begin
            acc <= sum;
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ahfp_fixed_acc.sv
// tb/tb_ahfp_fixed_acc.sv - directed self-checking bench for ahfp_fixed_acc
module tb_ahfp_fixed_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_sat;
    logic [8:0]  out_count;

    int errors = 0;
    int checks = 0;

    ahfp_fixed_acc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic beat(input logic [31:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic [31:0] d,
                                 input logic s, input logic [8:0] c);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s out_valid got %b exp 1", name, out_valid);
        end
        checks++;
        if (out_data !== d) begin
            errors++;
            $display("FAIL %s out_data got %h exp %h", name, out_data, d);
        end
        checks++;
        if (out_sat !== s) begin
            errors++;
            $display("FAIL %s out_sat got %b exp %b", name, out_sat, s);
        end
        checks++;
        if (out_count !== c) begin
            errors++;
            $display("FAIL %s out_count got %0d exp %0d", name, out_count, c);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h1234;
        in_last  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_data, out_sat, out_count} !== {1'b0, 32'h0, 1'b0, 9'd0}) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h s=%b c=%0d exp all zero",
                     out_valid, out_data, out_sat, out_count);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_valid got %b exp 0", out_valid);
        end
    endtask

    task automatic test_basic_frame();
        out_ready = 1'b1;
        beat(32'h0000_0003, 1'b0);
        beat(32'hFFFF_FFFE, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid got %b exp 0", out_valid);
        end
        beat(32'h0000_0010, 1'b1);
        expect_result("basic", 32'h0000_0011, 1'b0, 9'd3);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_in_ready_hold got %b exp 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_one_cycle got %b exp 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        beat(32'h7FFF_FFFF, 1'b0);
        beat(32'h7FFF_FFFF, 1'b1);
        expect_result("sat_pos", 32'h7FFF_FFFF, 1'b1, 9'd2);
        @(posedge clk); #1;
        beat(32'h8000_0000, 1'b0);
        beat(32'h8000_0000, 1'b1);
        expect_result("sat_neg", 32'h8000_0001, 1'b1, 9'd2);
        @(posedge clk); #1;
        beat(32'h8000_0000, 1'b1);
        expect_result("sat_single_min", 32'h8000_0001, 1'b1, 9'd1);
        @(posedge clk); #1;
        beat(32'h8000_0001, 1'b1);
        expect_result("edge_neg_nosat", 32'h8000_0001, 1'b0, 9'd1);
        @(posedge clk); #1;
        beat(32'h7FFF_FFFF, 1'b1);
        expect_result("edge_pos_nosat", 32'h7FFF_FFFF, 1'b0, 9'd1);
        @(posedge clk); #1;
    endtask

    task automatic test_max_len();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0001;
        in_last   = 1'b0;
        for (int i = 0; i < 255; i++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL maxlen_early_close got %b exp 0", out_valid);
        end
        @(posedge clk);
        #1;
        expect_result("maxlen", 32'h0000_0100, 1'b0, 9'd256);
        in_data = 32'h0000_0007;
        in_last = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL maxlen_dead_cycle got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        expect_result("beat257", 32'h0000_0007, 1'b0, 9'd1);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        beat(32'h0000_0012, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'h0000_0100;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_in_ready cyc %0d got %b exp 0", i, in_ready);
            end
            expect_result("hold_stable", 32'h0000_0012, 1'b0, 9'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release got %b exp 0", out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        expect_result("after_hold", 32'h0000_0100, 1'b0, 9'd1);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b1;
        beat(32'h0000_0055, 1'b0);
        beat(32'h0000_0055, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_sat, out_count} !== {1'b0, 32'h0, 1'b0, 9'd0}) begin
            errors++;
            $display("FAIL midreset_async got v=%b d=%h s=%b c=%0d exp all zero",
                     out_valid, out_data, out_sat, out_count);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat(32'h0000_0005, 1'b1);
        expect_result("after_midreset", 32'h0000_0005, 1'b0, 9'd1);
        @(posedge clk); #1;
    endtask

    task automatic test_last_without_valid();
        out_ready = 1'b1;
        beat(32'h0000_0002, 1'b0);
        in_last = 1'b1;
        in_data = 32'h0000_1000;
        @(posedge clk);
        #1;
        in_last = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL last_no_valid got %b exp 0", out_valid);
        end
        beat(32'hFFFF_FFFF, 1'b1);
        expect_result("last_no_valid_sum", 32'h0000_0001, 1'b0, 9'd2);
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_saturation();
        test_max_len();
        test_back_to_back();
        test_last_without_valid();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
